// File: rtl/local_port_arbiter_pkg.sv
// Shared types and helpers for the local port arbiter.
//   LPA_DW      : default flit payload width
//   flit_t      : one buffered flit {last, data}
//   arb_state_t : arbitration state (IDLE between packets, LOCKED while a packet owns the port)
//   wrap_inc    : modulo increment used for the round-robin pointer
package local_port_arbiter_pkg;

    localparam int LPA_DW = 32;

    typedef struct packed {
        logic              last;
        logic [LPA_DW-1:0] data;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/local_port_arbiter_rr.sv
// Combinational round-robin search.
// Scans requests starting at i_ptr, wrapping modulo NUM_REQ, and reports the
// first set requester.
//   i_req  in   NUM_REQ  request vector
//   i_ptr  in   IDXW     index with highest priority this cycle
//   o_gnt  out  NUM_REQ  one-hot winner (0 when no request)
//   o_idx  out  IDXW     binary index of the winner
//   o_any  out  1        at least one request present
module local_port_arbiter_rr #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDXW-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDXW-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            // i_ptr is always < NUM_REQ, so one conditional subtract wraps correctly
            j = int'(i_ptr) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IDXW'(j);
            end
        end
    end

endmodule

// File: rtl/local_port_arbiter.sv
// Shares one router local input port among NUM_REQ packet producers.
// Round-robin arbitration locked per packet (head to tail), followed by a
// registered 2-entry output FIFO that decouples producers from router backpressure.
//   clk          in   1            clock
//   rstn         in   1            async active-low reset
//   req_valid_i  in   NUM_REQ      per-requester flit valid
//   req_data_i   in   NUM_REQ x DW per-requester flit payload
//   req_last_i   in   NUM_REQ      flit is packet tail
//   req_ready_o  out  NUM_REQ      per-requester accept (only the owner, only when buffer not full)
//   valid_o      out  1            flit available to router
//   data_o       out  DW           head flit payload (0 when buffer empty)
//   last_o       out  1            head flit tail marker (0 when buffer empty)
//   ready_i      in   1            router accepts head flit
//   grant_o      out  NUM_REQ      one-hot current owner, 0 when IDLE
//   busy_o       out  1            packet in progress or buffer non-empty
module local_port_arbiter
    import local_port_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DW      = LPA_DW,
    localparam int IDXW    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req_valid_i,
    input  logic [DW-1:0]      req_data_i [NUM_REQ],
    input  logic [NUM_REQ-1:0] req_last_i,
    output logic [NUM_REQ-1:0] req_ready_o,
    output logic               valid_o,
    output logic [DW-1:0]      data_o,
    output logic               last_o,
    input  logic               ready_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               busy_o
);

    arb_state_t         r_state;
    logic [IDXW-1:0]    r_ptr;
    logic [IDXW-1:0]    r_owner;
    logic [NUM_REQ-1:0] r_grant;

    // FIFO storage: bit DW is the tail marker, bits DW-1:0 the payload
    logic [DW:0]        r_mem [2];
    logic               r_wr_sel;
    logic               r_rd_sel;
    logic [1:0]         r_count;

    logic [NUM_REQ-1:0] w_arb_gnt;
    logic [IDXW-1:0]    w_arb_idx;
    logic               w_arb_any;
    logic               w_full;
    logic               w_empty;
    logic               w_accept;
    logic               w_pop;
    logic [DW:0]        w_push_flit;
    logic [DW:0]        w_head;

    local_port_arbiter_rr #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_rr (
        .i_req (req_valid_i),
        .i_ptr (r_ptr),
        .o_gnt (w_arb_gnt),
        .o_idx (w_arb_idx),
        .o_any (w_arb_any)
    );

    // Full comes from the registered count only, so ready_i never reaches req_ready_o
    assign w_full      = (r_count == 2'd2);
    assign w_empty     = (r_count == 2'd0);
    assign w_accept    = (r_state == LOCKED) && req_valid_i[r_owner] && !w_full;
    assign w_push_flit = {req_last_i[r_owner], req_data_i[r_owner]};
    assign w_pop       = !w_empty && ready_i;
    assign w_head      = r_mem[r_rd_sel];

    // Arbitration FSM: IDLE picks an owner, LOCKED holds it until the tail flit is accepted
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_owner <= '0;
            r_grant <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_arb_any) begin
                        r_owner <= w_arb_idx;
                        r_grant <= w_arb_gnt;
                        r_state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (w_accept && req_last_i[r_owner]) begin
                        r_state <= IDLE;
                        r_grant <= '0;
                        r_ptr   <= IDXW'(wrap_inc(int'(r_owner), NUM_REQ));
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_accept) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_pop) begin
                r_rd_sel <= ~r_rd_sel;
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload needs no reset: it is only observed while the count says it is valid
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_sel] <= w_push_flit;
        end
    end

    assign req_ready_o = ((r_state == LOCKED) && !w_full) ? r_grant : '0;
    assign valid_o     = !w_empty;
    assign data_o      = w_empty ? '0 : w_head[DW-1:0];
    assign last_o      = !w_empty && w_head[DW];
    assign grant_o     = r_grant;
    assign busy_o      = (r_state == LOCKED) || !w_empty;

endmodule
